// File: rtl/spi_reg_pkg.sv
// Shared constants and FSM state type for the SPI register bank.
package spi_reg_pkg;
  localparam int CMD_RW_BIT  = 7;
  localparam int BYTE_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    IGNORE
  } spi_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_reg_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing NUM_OUT control and NUM_IN status registers.
// Define SPI_BURST_AUTOINC_EN to auto-increment the address after every data byte.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_OUT = 8,
  parameter int NUM_IN  = 4,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_cs,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      miso_oe,
  input  logic [NUM_IN*BYTE_W-1:0]  in_regs,
  output logic [NUM_OUT*BYTE_W-1:0] out_regs,
  output logic [NUM_OUT-1:0]        wr_stb,
  output logic [NUM_IN-1:0]         rd_stb,
  output logic [ADDR_W-1:0]         spi_addr
);
  localparam int CNT_W = $clog2(BYTE_W);

  logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic                   mosi_s;
  spi_state_t             state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [BYTE_W-2:0]      shift_reg;
  logic [BYTE_W-1:0]      tx_reg, rx_byte, load_value;
  logic                   rw_reg, load_pend_reg, byte_done;
  logic [ADDR_W-1:0]      addr_reg;
  logic [BYTE_W-1:0]      regs [NUM_OUT];
  logic [NUM_OUT-1:0]     wr_dec, wr_hit_reg;
  logic [NUM_IN-1:0]      rd_dec;

  spi_sync_edge u_cs_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_cs), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge u_clk_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_clk), .rise(sclk_rise), .fall(sclk_fall)
  );

  // MOSI shares the synchroniser depth so it lines up with the sclk_rise pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync_reg <= '0;
    else          mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign rx_byte   = {shift_reg, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt_reg == CNT_W'(BYTE_W-1)) && (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cs_rise) state_next = CMD;
      CMD: begin
        if (byte_done) begin
`ifdef SPI_BURST_AUTOINC_EN
          state_next = DATA;
`else
          state_next = (int'(rx_byte[ADDR_W-1:0]) < NUM_OUT + NUM_IN) ? DATA : IGNORE;
`endif
        end
      end
      DATA: begin
`ifdef SPI_BURST_AUTOINC_EN
        state_next = DATA;
`else
        if (byte_done) state_next = IGNORE;
`endif
      end
      default: state_next = state_reg;
    endcase
    if (cs_fall) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Address decode; readback is forced to zero outside DATA so IGNORE shifts zeros.
  always_comb begin
    wr_dec     = '0;
    rd_dec     = '0;
    load_value = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (int'(addr_reg) == i) begin
        wr_dec[i]  = 1'b1;
        load_value = regs[i];
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(addr_reg) == NUM_OUT + k) begin
        rd_dec[k]  = 1'b1;
        load_value = in_regs[k*BYTE_W +: BYTE_W];
      end
    end
    if (state_reg != DATA) begin
      rd_dec     = '0;
      load_value = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      rw_reg        <= 1'b0;
      load_pend_reg <= 1'b0;
      addr_reg      <= '0;
      wr_hit_reg    <= '0;
      wr_stb        <= '0;
      rd_stb        <= '0;
      miso_oe       <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) regs[i] <= '0;
    end else begin
      wr_stb     <= wr_hit_reg;
      wr_hit_reg <= '0;
      rd_stb     <= '0;
      if (state_reg == IDLE) begin
        bit_cnt_reg   <= '0;
        load_pend_reg <= 1'b0;
        tx_reg        <= '0;
        miso_oe       <= 1'b0;
      end else begin
        if (sclk_rise) begin
          shift_reg   <= rx_byte[BYTE_W-2:0];
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        if (byte_done) begin
          if (state_reg == CMD) begin
            rw_reg        <= rx_byte[CMD_RW_BIT];
            addr_reg      <= rx_byte[ADDR_W-1:0];
            miso_oe       <= ~rx_byte[CMD_RW_BIT];
            load_pend_reg <= ~rx_byte[CMD_RW_BIT];
          end else begin
            load_pend_reg <= ~rw_reg;
            if (state_reg == DATA) begin
              if (rw_reg) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                  if (wr_dec[i]) regs[i] <= rx_byte;
                end
                wr_hit_reg <= wr_dec;
              end
`ifdef SPI_BURST_AUTOINC_EN
              addr_reg <= addr_reg + 1'b1;
`endif
            end
          end
        end
        if (sclk_fall) begin
          if (load_pend_reg) begin
            tx_reg        <= load_value;
            rd_stb        <= rd_dec;
            load_pend_reg <= 1'b0;
          end else begin
            tx_reg <= {tx_reg[BYTE_W-2:0], 1'b0};
          end
        end
        // A byte completing in the same cycle is already committed above.
        if (cs_fall) begin
          bit_cnt_reg   <= '0;
          load_pend_reg <= 1'b0;
          tx_reg        <= '0;
          miso_oe       <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    assign out_regs[gi*BYTE_W +: BYTE_W] = regs[gi];
  end

  assign spi_miso = tx_reg[BYTE_W-1];
  assign spi_addr = addr_reg;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios plus random frames vs. a register-map model.
module tb_spi_reg_bank;
  localparam int NO   = 8;
  localparam int NI   = 4;
  localparam int HALF = 80;
`ifdef SPI_BURST_AUTOINC_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            spi_cs = 1'b0;
  logic            spi_clk = 1'b0;
  logic            spi_mosi = 1'b0;
  logic            spi_miso, miso_oe;
  logic [NI*8-1:0] in_regs = '0;
  logic [NO*8-1:0] out_regs;
  logic [NO-1:0]   wr_stb;
  logic [NI-1:0]   rd_stb;
  logic [6:0]      spi_addr;

  spi_reg_bank #(.NUM_OUT(NO), .NUM_IN(NI), .ADDR_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .miso_oe(miso_oe),
    .in_regs(in_regs), .out_regs(out_regs), .wr_stb(wr_stb),
    .rd_stb(rd_stb), .spi_addr(spi_addr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  // Strobe counters and change timestamps, sampled on the inactive edge.
  int              wr_cnt [NO];
  int              rd_cnt [NI];
  int              cyc = 0, chg_cyc = 0, stb_cyc = 0;
  logic [NO*8-1:0] prev_out = '0;
  initial begin
    for (int i = 0; i < NO; i++) wr_cnt[i] = 0;
    for (int k = 0; k < NI; k++) rd_cnt[k] = 0;
  end
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NO; i++) if (wr_stb[i] === 1'b1) wr_cnt[i] <= wr_cnt[i] + 1;
    for (int k = 0; k < NI; k++) if (rd_stb[k] === 1'b1) rd_cnt[k] <= rd_cnt[k] + 1;
    if (out_regs !== prev_out) chg_cyc <= cyc;
    if (|wr_stb) stb_cyc <= cyc;
    prev_out <= out_regs;
  end

  // Reference register map and per-frame expectations.
  logic [7:0] m_out [NO];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic [7:0] exp_rx [8];
  int         exp_wr [NO];
  int         exp_rd [NI];
  int         wr_base [NO];
  int         rd_base [NI];
  logic [6:0] exp_addr;
  logic       oe_cmd_any, oe_dat_all, oe_dat_any;

  task automatic model_read(input int a, output logic [7:0] v);
    v = 8'h00;
    if (a < NO) v = m_out[a];
    else if (a < NO + NI) begin
      v = in_regs[(a-NO)*8 +: 8];
      exp_rd[a-NO]++;
    end
  endtask

  // Register-map semantics of one frame: command in tx_buf[0], n data bytes after it.
  task automatic model_frame(input int n);
    int a;
    logic rw;
    logic [7:0] v;
    a  = int'(tx_buf[0][6:0]);
    rw = tx_buf[0][7];
    for (int i = 0; i < NO; i++) exp_wr[i] = 0;
    for (int k = 0; k < NI; k++) exp_rd[k] = 0;
    for (int j = 1; j <= n; j++) begin
      exp_rx[j] = 8'h00;
      if (j == 1 || BURST) begin
        if (rw) begin
          if (a < NO) begin
            m_out[a] = tx_buf[j];
            exp_wr[a]++;
          end
        end else begin
          model_read(a, v);
          exp_rx[j] = v;
        end
        if (BURST) a = (a + 1) % 128;
      end
    end
    // The load after the final byte still fetches the next register in a burst.
    if (!rw && BURST) model_read(a, v);
    exp_addr = a[6:0];
  endtask

  task automatic snap_counts();
    for (int i = 0; i < NO; i++) wr_base[i] = wr_cnt[i];
    for (int k = 0; k < NI; k++) rd_base[k] = rd_cnt[k];
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int b = 7; b >= 8 - nbits; b--) begin
      spi_mosi = tx[b];
      #HALF;
      rx[b]  = spi_miso;
      oe_all = oe_all & miso_oe;
      oe_any = oe_any | miso_oe;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n);
    logic a, b, c;
    snap_counts();
    spi_cs = 1'b1;
    #HALF;
    spi_byte(tx_buf[0], 8, rx_buf[0], a, oe_cmd_any);
    oe_dat_all = 1'b1;
    oe_dat_any = 1'b0;
    for (int j = 1; j <= n; j++) begin
      spi_byte(tx_buf[j], 8, rx_buf[j], b, c);
      oe_dat_all = oe_dat_all & b;
      oe_dat_any = oe_dat_any | c;
    end
    #HALF;
    spi_cs = 1'b0;
    #(2*HALF);
    $display("[TB] frame cmd=%02h bytes=%0d spi_addr=%02h", tx_buf[0], n, spi_addr);
  endtask

  task automatic test_reset();
    #22;
    tests_run++; if (out_regs !== '0) begin fails++; $display("FAIL reset_out_regs: got %h want 0", out_regs); end
    tests_run++; if (wr_stb !== '0)   begin fails++; $display("FAIL reset_wr_stb: got %h want 0", wr_stb); end
    tests_run++; if (rd_stb !== '0)   begin fails++; $display("FAIL reset_rd_stb: got %h want 0", rd_stb); end
    tests_run++; if (spi_miso !== 1'b0 || miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b/%b want 0/0", spi_miso, miso_oe); end
    tests_run++; if (spi_addr !== '0) begin fails++; $display("FAIL reset_spi_addr: got %h want 0", spi_addr); end
    reset_n = 1'b1;
    #50;
    for (int i = 0; i < NO; i++) m_out[i] = 8'h00;
    $display("[TB] reset released");
  endtask

  task automatic test_single_write();
    int others;
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h5A;
    model_frame(1);
    spi_frame(1);
    others = 0;
    for (int i = 0; i < NO; i++) if (i != 3) others += (wr_cnt[i] - wr_base[i]);
    tests_run++; if (out_regs[3*8 +: 8] !== 8'h5A) begin fails++; $display("FAIL single_write_value: got %h want 5a", out_regs[3*8 +: 8]); end
    tests_run++; if ((out_regs & ~(64'hFF << 24)) !== '0) begin fails++; $display("FAIL single_write_others: got %h want only reg3 set", out_regs); end
    tests_run++; if (wr_cnt[3] - wr_base[3] !== 1 || others !== 0) begin fails++; $display("FAIL single_write_stb: got %0d/%0d want 1/0", wr_cnt[3] - wr_base[3], others); end
    tests_run++; if (stb_cyc - chg_cyc !== 1) begin fails++; $display("FAIL single_write_stb_delay: got %0d want 1", stb_cyc - chg_cyc); end
  endtask

  task automatic test_status_read();
    for (int k = 0; k < NI; k++) in_regs[k*8 +: 8] = 8'($urandom);
    in_regs[15:8] = 8'hC3;
    tx_buf[0] = 8'h09; tx_buf[1] = 8'h00;
    model_frame(1);
    spi_frame(1);
    tests_run++; if (rx_buf[1] !== 8'hC3) begin fails++; $display("FAIL status_read_data: got %h want c3", rx_buf[1]); end
    tests_run++; if (rd_cnt[1] - rd_base[1] !== 1) begin fails++; $display("FAIL status_read_rd_stb: got %0d want 1", rd_cnt[1] - rd_base[1]); end
    tests_run++; if (oe_cmd_any !== 1'b0 || oe_dat_all !== 1'b1) begin fails++; $display("FAIL status_read_oe: got cmd=%b data=%b want 0/1", oe_cmd_any, oe_dat_all); end
    tests_run++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL status_read_oe_after: got %b want 0", miso_oe); end
  endtask

  task automatic test_readback_oor();
    logic [NO*8-1:0] snap;
    int total;
    tx_buf[0] = 8'h80; tx_buf[1] = 8'hA5; model_frame(1); spi_frame(1);
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; model_frame(1); spi_frame(1);
    tests_run++; if (rx_buf[1] !== 8'hA5) begin fails++; $display("FAIL readback_reg0: got %h want a5", rx_buf[1]); end
    tx_buf[0] = 8'h7F; model_frame(1); spi_frame(1);
    tests_run++; if (rx_buf[1] !== 8'h00) begin fails++; $display("FAIL read_oor: got %h want 00", rx_buf[1]); end
    snap = out_regs;
    tx_buf[0] = 8'hFF; tx_buf[1] = 8'h11; model_frame(1); spi_frame(1);
    total = 0;
    for (int i = 0; i < NO; i++) total += wr_cnt[i] - wr_base[i];
    tests_run++; if (out_regs !== snap) begin fails++; $display("FAIL write_oor_regs: got %h want %h", out_regs, snap); end
    tests_run++; if (total !== 0) begin fails++; $display("FAIL write_oor_stb: got %0d want 0", total); end
  endtask

  task automatic test_burst();
    logic [7:0] e7;
    logic [6:0] ea;
`ifdef SPI_BURST_AUTOINC_EN
    e7 = 8'h02; ea = 7'd9;
`else
    e7 = m_out[7]; ea = 7'd6;
`endif
    tx_buf[0] = 8'h86; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02; tx_buf[3] = 8'h03;
    model_frame(3);
    spi_frame(3);
    tests_run++; if (out_regs[6*8 +: 8] !== 8'h01) begin fails++; $display("FAIL burst_reg6: got %h want 01", out_regs[6*8 +: 8]); end
    tests_run++; if (out_regs[7*8 +: 8] !== e7) begin fails++; $display("FAIL burst_reg7: got %h want %h", out_regs[7*8 +: 8], e7); end
    tests_run++; if (spi_addr !== ea) begin fails++; $display("FAIL burst_spi_addr: got %h want %h", spi_addr, ea); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    logic a, b;
    int total;
    snap_counts();
    spi_cs = 1'b1;
    #HALF;
    spi_byte(8'h82, 8, r, a, b);
    spi_byte(8'hFF, 5, r, a, b);
    #HALF;
    spi_cs = 1'b0;
    #(2*HALF);
    $display("[TB] aborted frame cmd=82 after 5 data bits");
    total = 0;
    for (int i = 0; i < NO; i++) total += wr_cnt[i] - wr_base[i];
    tests_run++; if (out_regs[2*8 +: 8] !== m_out[2]) begin fails++; $display("FAIL abort_reg2: got %h want %h", out_regs[2*8 +: 8], m_out[2]); end
    tests_run++; if (total !== 0 || miso_oe !== 1'b0) begin fails++; $display("FAIL abort_stb_oe: got %0d/%b want 0/0", total, miso_oe); end
    tx_buf[0] = 8'h82; tx_buf[1] = 8'h33;
    model_frame(1);
    spi_frame(1);
    tests_run++; if (out_regs[2*8 +: 8] !== 8'h33) begin fails++; $display("FAIL abort_next_frame: got %h want 33", out_regs[2*8 +: 8]); end
    tests_run++; if (wr_cnt[2] - wr_base[2] !== 1) begin fails++; $display("FAIL abort_next_stb: got %0d want 1", wr_cnt[2] - wr_base[2]); end
  endtask

  task automatic test_cs_on_last_edge();
    logic [7:0] r;
    logic a, b;
    snap_counts();
    spi_cs = 1'b1;
    #HALF;
    spi_byte(8'h84, 8, r, a, b);
    spi_byte(8'h6C, 7, r, a, b);
    spi_mosi = 1'b0;
    #HALF;
    spi_clk = 1'b1;
    spi_cs  = 1'b0;
    #HALF;
    spi_clk = 1'b0;
    #(2*HALF);
    m_out[4] = 8'h6C;
    $display("[TB] frame cmd=84 data=6c with cs falling on the last rise");
    tests_run++; if (out_regs[4*8 +: 8] !== 8'h6C) begin fails++; $display("FAIL cs_last_edge_reg4: got %h want 6c", out_regs[4*8 +: 8]); end
    tests_run++; if (wr_cnt[4] - wr_base[4] !== 1) begin fails++; $display("FAIL cs_last_edge_stb: got %0d want 1", wr_cnt[4] - wr_base[4]); end
  endtask

  task automatic test_random();
    int n;
    logic rw;
    logic oe_ok;
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < NI; k++) in_regs[k*8 +: 8] = 8'($urandom);
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      tx_buf[0] = {rw, ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 13))};
      for (int j = 1; j <= n; j++) tx_buf[j] = 8'($urandom);
      model_frame(n);
      spi_frame(n);
      tests_run++; if (spi_addr !== exp_addr) begin fails++; $display("FAIL rand_spi_addr f%0d: got %h want %h", f, spi_addr, exp_addr); end
      for (int i = 0; i < NO; i++) begin
        tests_run++; if (out_regs[i*8 +: 8] !== m_out[i]) begin fails++; $display("FAIL rand_reg%0d f%0d: got %h want %h", i, f, out_regs[i*8 +: 8], m_out[i]); end
        tests_run++; if (wr_cnt[i] - wr_base[i] !== exp_wr[i]) begin fails++; $display("FAIL rand_wr_stb%0d f%0d: got %0d want %0d", i, f, wr_cnt[i] - wr_base[i], exp_wr[i]); end
      end
      for (int k = 0; k < NI; k++) begin
        tests_run++; if (rd_cnt[k] - rd_base[k] !== exp_rd[k]) begin fails++; $display("FAIL rand_rd_stb%0d f%0d: got %0d want %0d", k, f, rd_cnt[k] - rd_base[k], exp_rd[k]); end
      end
      if (!rw) begin
        for (int j = 1; j <= n; j++) begin
          tests_run++; if (rx_buf[j] !== exp_rx[j]) begin fails++; $display("FAIL rand_miso f%0d b%0d: got %h want %h", f, j, rx_buf[j], exp_rx[j]); end
        end
      end
      oe_ok = rw ? ~oe_dat_any : oe_dat_all;
      tests_run++; if (oe_ok !== 1'b1 || oe_cmd_any !== 1'b0) begin fails++; $display("FAIL rand_oe f%0d: got data_ok=%b cmd=%b want 1/0", f, oe_ok, oe_cmd_any); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r;
    logic a, b;
    spi_cs = 1'b1;
    #HALF;
    spi_byte(8'h09, 8, r, a, b);
    spi_byte(8'h00, 4, r, a, b);
    tests_run++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL mid_read_oe_before: got %b want 1", miso_oe); end
    reset_n = 1'b0;
    #1;
    tests_run++; if (out_regs !== '0 || wr_stb !== '0 || rd_stb !== '0) begin fails++; $display("FAIL mid_reset_regs: got %h/%h/%h want 0", out_regs, wr_stb, rd_stb); end
    tests_run++; if (spi_miso !== 1'b0 || miso_oe !== 1'b0 || spi_addr !== '0) begin fails++; $display("FAIL mid_reset_io: got %b/%b/%h want 0/0/0", spi_miso, miso_oe, spi_addr); end
    spi_cs = 1'b0;
    spi_clk = 1'b0;
    #100;
    reset_n = 1'b1;
    #50;
    for (int i = 0; i < NO; i++) m_out[i] = 8'h00;
    $display("[TB] reset asserted mid read and released");
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h77; model_frame(1); spi_frame(1);
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h00; model_frame(1); spi_frame(1);
    tests_run++; if (rx_buf[1] !== 8'h77) begin fails++; $display("FAIL post_reset_readback: got %h want 77", rx_buf[1]); end
    tests_run++; if (out_regs !== 64'h0000_0000_0000_7700) begin fails++; $display("FAIL post_reset_regs: got %h want 7700", out_regs); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_write();
    test_status_read();
    test_readback_oor();
    test_burst();
    test_abort();
    test_cs_on_last_edge();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
